// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer that turns bit-reversed FFT output into natural-order bins.
// One bank is filled at bit-reversed addresses while the other is read out sequentially.
module fft_bitrev_reorder #(
  parameter int data_resolution = 16,
  parameter int fft_length      = 65536
) (
  input  logic                       sys_clk,
  input  logic                       sys_nrst,
  input  logic                       sys_en,
  input  logic                       din_valid,
  input  logic                       din_sof,
  input  logic [data_resolution-1:0] din_r,
  input  logic [data_resolution-1:0] din_i,
  output logic [data_resolution-1:0] dout_r,
  output logic [data_resolution-1:0] dout_i,
  output logic                       dout_valid,
  output logic                       dout_sof
);

  localparam int AW = $clog2(fft_length);
  localparam int DW = 2 * data_resolution;

  typedef logic [AW-1:0] addr_t;

  localparam addr_t LAST = addr_t'(fft_length - 1);

  function automatic addr_t bitrev(input addr_t a);
    addr_t r;
    for (int b = 0; b < AW; b++) r[b] = a[AW-1-b];
    return r;
  endfunction

  logic [DW-1:0] bank0 [fft_length];
  logic [DW-1:0] bank1 [fft_length];

  addr_t         wr_cnt;
  addr_t         rd_cnt;
  logic          wr_bank;
  logic          rd_bank;
  logic          seen_sof;
  logic [1:0]    full;
  logic [1:0]    full_nxt;
  logic [DW-1:0] ram_q;
  logic          rd_vld;
  logic          rd_sof;

  logic          accept;
  logic          wr_last;
  addr_t         wr_addr;
  logic          rd_go;
  logic          rd_last;

  // Samples before the first SOF are dropped; an SOF always restarts the frame at address 0.
  always_comb begin
    accept   = sys_en & din_valid & (din_sof | seen_sof);
    wr_last  = !din_sof && (wr_cnt == LAST);
    wr_addr  = din_sof ? '0 : bitrev(wr_cnt);
    rd_go    = sys_en & full[rd_bank];
    rd_last  = (rd_cnt == LAST);
    full_nxt = full;
    if (rd_go && rd_last) full_nxt[rd_bank] = 1'b0;
    if (accept && wr_last) full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      seen_sof <= 1'b0;
      full     <= 2'b00;
    end else if (sys_en) begin
      full <= full_nxt;
      if (accept) begin
        seen_sof <= 1'b1;
        if (din_sof) begin
          wr_cnt <= addr_t'(1);
        end else if (wr_last) begin
          wr_cnt  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_cnt <= wr_cnt + addr_t'(1);
        end
      end
      if (rd_go) begin
        if (rd_last) begin
          rd_cnt  <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          rd_cnt <= rd_cnt + addr_t'(1);
        end
      end
    end
  end

  // Banks carry no reset so they map onto block RAM; the read is registered.
  always_ff @(posedge sys_clk) begin
    if (accept) begin
      if (!wr_bank) bank0[wr_addr] <= {din_r, din_i};
      else          bank1[wr_addr] <= {din_r, din_i};
    end
    if (rd_go) ram_q <= rd_bank ? bank1[rd_cnt] : bank0[rd_cnt];
  end

  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      rd_vld     <= 1'b0;
      rd_sof     <= 1'b0;
      dout_valid <= 1'b0;
      dout_sof   <= 1'b0;
      dout_r     <= '0;
      dout_i     <= '0;
    end else if (sys_en) begin
      rd_vld     <= rd_go;
      rd_sof     <= rd_go && (rd_cnt == '0);
      dout_valid <= rd_vld;
      dout_sof   <= rd_sof;
      if (rd_vld) {dout_r, dout_i} <= ram_q;
    end
  end

endmodule

// File: doc/fft_bitrev_reorder.md
FFT_BITREV_REORDER -- requirements
Module: fft_bitrev_reorder

Interface
REQ-001 The block SHALL have parameter data_resolution, default 16: width of each real/imag sample.
REQ-002 The block SHALL have parameter fft_length, default 65536: frame length N, a power of 2 from 16 to 65536; AW = log2(N).
REQ-003 The block SHALL have port sys_clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port sys_nrst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port sys_en, input, 1 bit: global enable; all state holds when low.
REQ-006 The block SHALL have port din_valid, input, 1 bit: input sample present.
REQ-007 The block SHALL have port din_sof, input, 1 bit: first sample of a frame, qualified by din_valid.
REQ-008 The block SHALL have ports din_r and din_i, input, data_resolution bits each: bit-reversed-order FFT output from the R2^2 SDF pipeline.
REQ-009 The block SHALL have ports dout_r and dout_i, output, data_resolution bits each: natural-order FFT bins.
REQ-010 The block SHALL have port dout_valid, output, 1 bit: a bin is on dout_r/dout_i.
REQ-011 The block SHALL have port dout_sof, output, 1 bit: bin 0 of a frame, asserted only with dout_valid.

Function
REQ-012 The block SHALL contain two N-entry banks (ping-pong), each entry holding 2*data_resolution bits.
REQ-013 The block SHALL accept a sample only on a cycle where sys_en=1 and din_valid=1.
REQ-014 An accepted sample SHALL be written to the write bank at address bitrev(wr_cnt) over AW bits; wr_cnt SHALL then increment.
REQ-015 An accepted sample with din_sof=1 SHALL be written at address 0 with wr_cnt set to 1; any partial frame in the write bank SHALL be discarded without a bank swap.
REQ-016 Samples accepted before the first din_sof after reset SHALL be ignored: no write and no count.
REQ-017 When the sample at wr_cnt=N-1 is accepted, wr_cnt SHALL wrap to 0, the bank roles SHALL swap, and the completed bank SHALL be marked full.
REQ-018 While a full bank exists and sys_en=1, the read side SHALL issue natural address rd_cnt = 0..N-1, one per cycle; after N-1 it SHALL clear that bank's full flag.
REQ-019 Read data SHALL pass through one synchronous RAM read stage and one output register.
REQ-020 dout_valid SHALL rise at the 2nd enabled rising edge after the edge accepting the last sample of a frame.
REQ-021 dout_sof SHALL be high together with the bin at rd_cnt=0.
REQ-022 If a new bank completes exactly as the current read finishes, the next read SHALL start on the following enabled cycle, giving gapless output with no dropped bin.
REQ-023 Writes and reads are both gated by sys_en, so overflow cannot occur; a swap request while the other bank is still full SHALL NOT happen under legal input.
REQ-024 Simultaneous write to one bank and read from the other SHALL be supported every cycle.
REQ-025 dout_r and dout_i SHALL hold their last value when dout_valid=0.
REQ-026 When sys_en=0, all counters, flags, pipeline registers and outputs SHALL hold.

Reset
REQ-027 While sys_nrst=0, wr_cnt, rd_cnt, bank select, full flags and the "seen first SOF" flag SHALL clear to 0, asynchronously.
REQ-028 While sys_nrst=0, dout_r, dout_i, dout_valid and dout_sof SHALL be 0; RAM contents need not be reset.
REQ-029 A reset during a read or write SHALL abort the frame; after release, output SHALL stay invalid until a full frame starting with din_sof is accepted.

Verification (fft_length=16, data_resolution=16)
REQ-030 Single frame: din_r=k, din_i=-k, k=0..15, din_sof at k=0 -> dout_r sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15, dout_i its negation, dout_sof on the first bin, dout_valid high 16 cycles starting 2 cycles after k=15.
REQ-031 Back-to-back frames: 3 frames, values 0..47 continuous -> 48 contiguous valid outputs, each frame bit-reversed within itself, dout_sof every 16 bins.
REQ-032 sys_en toggled pseudo-randomly at 50% during input and output -> output sequence identical to REQ-030, with all state frozen on sys_en=0 cycles.
REQ-033 din_sof re-asserted at k=6 of a frame, then 16 samples -> only the restarted 16-sample frame is output; the partial frame is never output.
REQ-034 sys_nrst pulsed low mid-read at bin 5 -> all outputs 0 immediately, no further dout_valid until a new complete frame.
REQ-035 din_valid high without a prior din_sof after reset for 20 cycles -> no dout_valid.
